// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg: shared constants and types for the sram_resp block.
//   - default parameter values for sram_resp
//   - stall LFSR seed and tap mask (used only when SRAM_RESP_STALL_EN is defined)
//   - entry_t: one outstanding response held in the in-order queue
package sram_resp_pkg;

  localparam int DEF_MEM_AW  = 10;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_LATENCY = 2;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic [3:0]  countdown;
  } entry_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: in-order response queue with a per-entry down-counter.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   push, push_entry     enqueue one entry at the tail (caller guarantees !full)
//   pop                  dequeue the head (caller pops only when head_ready)
//   head_ready           head entry valid and its countdown reached zero
//   head_wr, head_data   head entry fields
//   full                 occupancy == DEPTH (registered state only)
module sram_resp_fifo
  import sram_resp_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  entry_t      push_entry,
  input  logic        pop,
  output logic        head_ready,
  output logic        head_wr,
  output logic [31:0] head_data,
  output logic        full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  entry_t           slot [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [PW:0]      count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && slot[i].countdown != 4'd0)
          slot[i].countdown <= slot[i].countdown - 4'd1;
      end
      if (pop) begin
        valid[head_ptr] <= 1'b0;
        head_ptr        <= head_ptr + 1'b1;
      end
      // push never targets the popped slot: push needs !full, pop needs count>0
      if (push) begin
        slot[tail_ptr]  <= push_entry;
        valid[tail_ptr] <= 1'b1;
        tail_ptr        <= tail_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_ready = valid[head_ptr] && (slot[head_ptr].countdown == 4'd0);
  assign head_wr    = slot[head_ptr].wr;
  assign head_data  = slot[head_ptr].data;
  assign full       = (count == DEPTH_C);

endmodule

// File: rtl/sram_resp.sv
// sram_resp: SRAM-like slave with fixed minimum response latency.
// Requests are accepted while the response queue has room; writes commit on
// the acceptance edge, reads snapshot the word on the acceptance edge, and
// responses retire strictly in order, one data_ok pulse each.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   req, wr, size, wstrb     request valid, write flag, size (ignored), byte enables
//   addr, wdata              byte address (word index addr[MEM_AW+1:2]), write data
//   addr_ok                  request accepted this cycle when req=1
//   data_ok, rdata           response pulse and its data (0 for writes; held otherwise)
// Build option: define SRAM_RESP_STALL_EN to gate addr_ok with a free-running LFSR.
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int MEM_AW  = DEF_MEM_AW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [31:0]       mem [1<<MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic              accept;
  logic              stall_ok;
  logic              full;
  logic              head_ready;
  logic              head_wr;
  logic [31:0]       head_data;
  logic [31:0]       resp_data;
  logic [31:0]       rdata_q;
  entry_t            push_entry;

  wire logic unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  assign idx = addr[MEM_AW+1:2];

`ifdef SRAM_RESP_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall_ok = lfsr[0];
`else
  assign stall_ok = 1'b1;
`endif

  // Gating with resetn keeps the reset cycle free of acceptances and of
  // responses for requests that are about to be discarded.
  assign addr_ok = resetn && !full && stall_ok;
  assign accept  = req && addr_ok;
  assign data_ok = resetn && head_ready;

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read data is taken from the pre-edge memory word, so a later write to the
  // same word cannot disturb a read that is already queued.
  always_comb begin
    push_entry           = '0;
    push_entry.wr        = wr;
    push_entry.data      = mem[idx];
    push_entry.countdown = 4'(LATENCY - 1);
  end

  sram_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (data_ok),
    .head_ready (head_ready),
    .head_wr    (head_wr),
    .head_data  (head_data),
    .full       (full)
  );

  assign resp_data = head_wr ? 32'h0 : head_data;

  always_ff @(posedge clk) begin
    if (!resetn)      rdata_q <= 32'h0;
    else if (data_ok) rdata_q <= resp_data;
  end

  assign rdata = data_ok ? resp_data : rdata_q;

endmodule
